// File: rtl/fetch_unit_if.sv
// fetch_unit_if: ROM read port, redirect input and decode handshake of the fetch stage.
interface fetch_unit_if #(parameter int SIZE = 5);
  logic [SIZE+2:0] rom_addr;
  logic [2:0]      rom_size;
  logic            rom_en;
  logic [31:0]     rom_data;
  logic            rom_exception;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [31:0]     instr_pc;
  logic            fetch_fault;
  logic [31:0]     fault_pc;
  modport master (
    output rom_addr, rom_size, rom_en, instr_valid, instr, instr_pc, fetch_fault, fault_pc,
    input  rom_data, rom_exception, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  rom_addr, rom_size, rom_en, instr_valid, instr, instr_pc, fetch_fault, fault_pc,
    output rom_data, rom_exception, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing word reads to the instruction ROM and handing instructions to decode.
// Define FETCH_BOUNDS_CHECK_EN to fault on PCs with bits set above the ROM byte address range.
module fetch_unit #(
  parameter int          SIZE     = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         CLK,
  input logic         RST_N,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;
  state_t      state;
  logic [31:0] pc;
  logic        bad;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign bad = bus.rom_exception || (|pc[31:SIZE+3]);
`else
  assign bad = bus.rom_exception;
`endif
  assign bus.rom_addr = pc[SIZE+2:0];
  assign bus.rom_size = 3'b010;
  assign bus.rom_en   = state == REQ;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      bus.instr_valid <= 1'b0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.fetch_fault <= 1'b0;
      bus.fault_pc    <= '0;
    end else if (bus.redirect_valid) begin
      state           <= REQ;
      pc              <= bus.redirect_pc;
      bus.instr_valid <= 1'b0;
      bus.fetch_fault <= 1'b0;
    end else begin
      if (bus.instr_valid && bus.instr_ready) bus.instr_valid <= 1'b0;
      case (state)
        IDLE: state <= REQ;
        REQ:
          if (bad) begin
            bus.fault_pc    <= pc;
            bus.fetch_fault <= 1'b1;
            state           <= FAULT;
          end else state <= RESP;
        RESP: begin
          // Data arriving while the slot is blocked is dropped and the same PC re-read.
          if (!bus.instr_valid || bus.instr_ready) begin
            bus.instr       <= bus.rom_data;
            bus.instr_pc    <= pc;
            bus.instr_valid <= 1'b1;
            pc              <= pc + 32'd4;
          end
          state <= REQ;
        end
        default: state <= FAULT;
      endcase
    end
endmodule
